// File: rtl/parity_frame_tx.sv
// parity_frame_tx
// Serial transmitter for the parity-protected link. A DATA_W-bit payload is
// accepted over a valid/ready handshake, extended with a parity bit, and sent
// as start (0), data LSB first, parity, stop (1), each held CLKS_PER_BIT
// clocks. The {parity, payload} frame is also exported in parallel.
// Build option: define ODD_PARITY_EN for odd parity (frame XORs to 1);
// the default build uses even parity (frame XORs to 0).
module parity_frame_tx #(
    parameter int DATA_W       = 5,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx_line,
    output logic              tx_busy,
    output logic [DATA_W:0]   frame_out,
    output logic              tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic              bit_end;
    logic              stop_pre_last;
    logic              par_bit;

    // Last clock of the current serial bit.
    assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // In STOP, the coming cycle is the final one, so tx_done can be registered.
    assign stop_pre_last = ((int'(cnt) + 2) == CLKS_PER_BIT);

    // Payload as it will look after the next bit-boundary shift; its LSB is the next data bit.
    assign shift_nxt = shift_reg >> 1;

`ifdef ODD_PARITY_EN
    assign par_bit = ~^din;
`else
    assign par_bit = ^din;
`endif

    // Frame sequencer: all outputs are registered so tx_line changes exactly on bit boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            frame_out <= '0;
            tx_line   <= 1'b1;
            tx_busy   <= 1'b0;
            din_ready <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all updates see pre-edge values, like real flops.
            case (state)
                IDLE: begin
                    tx_line <= 1'b1;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b0;
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (din_ready && din_valid) begin
                        shift_reg <= din;
                        frame_out <= {par_bit, din};
                        din_ready <= 1'b0;
                        tx_busy   <= 1'b1;
                        tx_line   <= 1'b0;
                        state     <= START;
                    end else begin
                        din_ready <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx_line <= shift_reg[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == IDX_W'(DATA_W - 1)) begin
                            tx_line <= frame_out[DATA_W];
                            state   <= PARITY;
                        end else begin
                            shift_reg <= shift_nxt;
                            tx_line   <= shift_nxt[0];
                            bit_idx   <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        tx_line <= 1'b1;
                        tx_done <= (CLKS_PER_BIT == 1);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        tx_done   <= 1'b0;
                        tx_busy   <= 1'b0;
                        din_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt     <= cnt + CNT_W'(1);
                        tx_done <= stop_pre_last;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx
// Self-checking bench for parity_frame_tx (DATA_W=5, CLKS_PER_BIT=4).
// Expected line waveforms are derived from the frame layout: bit slot b of
// (k-1)/CLKS_PER_BIT is start, payload bit, parity or stop.
module tb_parity_frame_tx;

    localparam int DW        = 5;
    localparam int CPB       = 4;
    localparam int FRAME_CYC = (DW + 3) * CPB;

`ifdef ODD_PARITY_EN
    localparam logic EXP_XOR = 1'b1;
`else
    localparam logic EXP_XOR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          tx_line;
    logic          tx_busy;
    logic [DW:0]   frame_out;
    logic          tx_done;

    int total = 0;
    int bad   = 0;

    parity_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .tx_line   (tx_line),
        .tx_busy   (tx_busy),
        .frame_out (frame_out),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Parity bit from the count of ones in the payload.
    function automatic logic model_parity(input logic [DW-1:0] w);
`ifdef ODD_PARITY_EN
        return ($countones(w) % 2) == 0;
`else
        return ($countones(w) % 2) == 1;
`endif
    endfunction

    // Expected line level in cycle k (1-based) after the accept edge.
    function automatic logic exp_line(input logic [DW:0] f, input int k);
        int b;
        b = (k - 1) / CPB;
        if (b == 0)       return 1'b0;
        if (b <= DW)      return f[b-1];
        if (b == DW + 1)  return f[DW];
        return 1'b1;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (din_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_ready: din_ready=%b after 100 cycles, required 1", din_ready);
        end
    endtask

    // Called just after a negedge where din/din_valid were offered with din_ready=1.
    task automatic run_frame(input logic [DW-1:0] w, input bit hold,
                             input logic [DW-1:0] nxt, input string tag);
        logic [DW:0] ef;
        ef = {model_parity(w), w};
        for (int k = 1; k <= FRAME_CYC; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total++;
                if (frame_out !== ef) begin
                    bad++;
                    $display("FAIL %s frame_out: got %b, required %b", tag, frame_out, ef);
                end
                if (!hold) din_valid = 1'b0;
            end
            total++;
            if (tx_line !== exp_line(ef, k)) begin
                bad++;
                $display("FAIL %s tx_line cycle %0d: got %b, required %b", tag, k, tx_line, exp_line(ef, k));
            end
            total++;
            if (tx_busy !== 1'b1 || din_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s busy/ready cycle %0d: got %b/%b, required 1/0", tag, k, tx_busy, din_ready);
            end
            total++;
            if (tx_done !== (k == FRAME_CYC)) begin
                bad++;
                $display("FAIL %s tx_done cycle %0d: got %b, required %b", tag, k, tx_done, (k == FRAME_CYC));
            end
            if (hold && k > 1 && k < FRAME_CYC) din = DW'($urandom);
            if (hold && k == FRAME_CYC)         din = nxt;
        end
        @(negedge clk);
        total++;
        if (tx_line !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || din_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s idle after frame: line/busy/done/ready=%b%b%b%b, required 1001",
                     tag, tx_line, tx_busy, tx_done, din_ready);
        end
        total++;
        if (frame_out !== ef) begin
            bad++;
            $display("FAIL %s frame_out held: got %b, required %b", tag, frame_out, ef);
        end
    endtask

    task automatic start_frame(input logic [DW-1:0] w, input bit hold,
                               input logic [DW-1:0] nxt, input string tag);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        din       = w;
        din_valid = 1'b1;
        run_frame(w, hold, nxt, tag);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (tx_line !== 1'b1 || tx_busy !== 1'b0 || din_ready !== 1'b0 || tx_done !== 1'b0 || frame_out !== '0) begin
            bad++;
            $display("FAIL reset outputs: line/busy/ready/done=%b%b%b%b frame=%b, required 1000 frame=000000",
                     tx_line, tx_busy, din_ready, tx_done, frame_out);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (din_ready !== 1'b1 || tx_line !== 1'b1) begin
            bad++;
            $display("FAIL reset release: ready/line=%b%b, required 11", din_ready, tx_line);
        end
    endtask

    task automatic test_directed();
        logic [DW:0] lit;
`ifdef ODD_PARITY_EN
        lit = 6'b010110;
`else
        lit = 6'b110110;
`endif
        start_frame(5'b10110, 1'b0, '0, "directed_10110");
        total++;
        if (frame_out !== lit) begin
            bad++;
            $display("FAIL directed literal: frame_out=%b, required %b", frame_out, lit);
        end
    endtask

    task automatic test_corners();
        logic [DW:0] lz;
        logic [DW:0] lo;
`ifdef ODD_PARITY_EN
        lz = 6'b100000;
        lo = 6'b011111;
`else
        lz = 6'b000000;
        lo = 6'b111111;
`endif
        start_frame(5'b00000, 1'b0, '0, "all_zero");
        total++;
        if (frame_out !== lz) begin
            bad++;
            $display("FAIL all_zero literal: frame_out=%b, required %b", frame_out, lz);
        end
        start_frame(5'b11111, 1'b0, '0, "all_one");
        total++;
        if (frame_out !== lo) begin
            bad++;
            $display("FAIL all_one literal: frame_out=%b, required %b", frame_out, lo);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            start_frame(DW'($urandom), 1'b0, '0, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w0, w1, w2;
        w0 = DW'($urandom);
        w1 = DW'($urandom);
        w2 = DW'($urandom);
        start_frame(w0, 1'b1, w1, "b2b_first");
        run_frame(w1, 1'b1, w2, "b2b_second");
        run_frame(w2, 1'b0, '0, "b2b_third");
    endtask

    task automatic test_midframe_reset();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        din       = DW'($urandom);
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (tx_line !== 1'b1 || tx_busy !== 1'b0 || din_ready !== 1'b0 || tx_done !== 1'b0) begin
            bad++;
            $display("FAIL midframe reset: line/busy/ready/done=%b%b%b%b, required 1000",
                     tx_line, tx_busy, din_ready, tx_done);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (din_ready !== 1'b1) begin
            bad++;
            $display("FAIL midframe release: din_ready=%b, required 1", din_ready);
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            total++;
            if (tx_done !== 1'b0 || tx_line !== 1'b1) begin
                bad++;
                $display("FAIL abandoned frame cycle %0d: done/line=%b%b, required 01", i, tx_done, tx_line);
            end
        end
        start_frame(DW'($urandom), 1'b0, '0, "after_reset");
    endtask

    task automatic test_parity_checker();
        for (int w = 0; w < 32; w++) begin
            start_frame(DW'(w), 1'b0, '0, "checker");
            total++;
            if ((^frame_out) !== EXP_XOR) begin
                bad++;
                $display("FAIL checker word %0d: frame XOR=%b, required %b", w, ^frame_out, EXP_XOR);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_corners();
        test_random();
        test_back_to_back();
        test_midframe_reset();
        test_parity_checker();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
